// File: rtl/conv_ctrl.sv
// 3x3 convolution sequencer: loads 9 weights per (filter, channel) pass, then
// sweeps window addresses and tags the tree output with accumulator controls.
module conv_ctrl #(
  parameter int LWIDTH  = 10,
  parameter int IMWIDTH = 12,
  parameter int NWIDTH  = 14,
  parameter int DELAY   = 5
) (
  input  logic               clk,
  input  logic               xrst,
  input  logic               req,
  input  logic [LWIDTH-1:0]  img_size,
  input  logic [LWIDTH-1:0]  ch_num,
  input  logic [LWIDTH-1:0]  fil_num,
  output logic               ack,
  output logic [IMWIDTH-1:0] mem_img_addr,
  output logic [NWIDTH-1:0]  mem_net_addr,
  output logic               wreg_we,
  output logic [3:0]         wreg_idx,
  output logic               conv_oe,
  output logic               out_v,
  output logic               out_first,
  output logic               out_last,
  output logic [IMWIDTH-1:0] out_addr
);

  localparam int WCW = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam logic [LWIDTH-1:0] LONE = LWIDTH'(1);

  typedef enum logic [1:0] {IDLE, WEIGHT, EXEC, WAIT} state_t;

  typedef struct packed {
    logic               v;
    logic               f;
    logic               l;
    logic [IMWIDTH-1:0] a;
  } tap_t;

  state_t state, state_nx;

  logic [LWIDTH-1:0]  sz, chn, filn, os;
  logic [IMWIDTH-1:0] sz_i, s2, os2;
  logic [LWIDTH-1:0]  x, y, m, n;
  logic [IMWIDTH-1:0] row_base, ch_base, out_nbase, pos;
  logic [NWIDTH-1:0]  wbase;
  logic [3:0]         k;
  logic [WCW-1:0]     wcnt;
  logic               net_v;
  logic               bad_size;
  logic               x_end, y_end, ch_last, fil_last, pass_end;
  logic [LWIDTH-1:0]  os_in;
  logic [IMWIDTH-1:0] img_in, os_in_i;
  tap_t               pipe [DELAY];
  tap_t               tap_in;

  assign img_in   = IMWIDTH'(img_size);
  assign os_in    = img_size - LWIDTH'(2);
  assign os_in_i  = IMWIDTH'(os_in);
  assign bad_size = (img_size < LWIDTH'(3)) || (ch_num == '0) || (fil_num == '0);

  assign x_end    = (x == os - LONE);
  assign y_end    = (y == os - LONE);
  assign ch_last  = (m == chn - LONE);
  assign fil_last = (n == filn - LONE);
  assign pass_end = x_end && y_end;

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req) state_nx = bad_size ? WAIT : WEIGHT;
      WEIGHT:  if (k == 4'd9) state_nx = EXEC;
      EXEC:    if (pass_end) state_nx = (ch_last && fil_last) ? WAIT : WEIGHT;
      WAIT:    if (wcnt == WCW'(DELAY - 1)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ack          = (state == IDLE);
    conv_oe      = (state == EXEC);
    net_v        = (state == WEIGHT) && (k < 4'd9);
    mem_net_addr = net_v ? wbase + NWIDTH'(k) : '0;
    mem_img_addr = conv_oe ? ch_base + row_base + IMWIDTH'(x) : '0;
  end

  // Loop counters; image/output addresses are kept as running bases so no
  // multiplier sits in the per-cycle path (only the two squares at latch time).
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      sz <= '0; chn <= '0; filn <= '0; os <= '0;
      sz_i <= '0; s2 <= '0; os2 <= '0;
      x <= '0; y <= '0; m <= '0; n <= '0;
      row_base <= '0; ch_base <= '0; out_nbase <= '0; pos <= '0;
      wbase <= '0; k <= '0; wcnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          wcnt <= '0;
          if (req) begin
            sz <= img_size; chn <= ch_num; filn <= fil_num; os <= os_in;
            sz_i <= img_in;
            s2   <= img_in * img_in;
            os2  <= os_in_i * os_in_i;
            x <= '0; y <= '0; m <= '0; n <= '0;
            row_base <= '0; ch_base <= '0; out_nbase <= '0; pos <= '0;
            wbase <= '0; k <= '0;
          end
        end
        WEIGHT: k <= (k == 4'd9) ? 4'd0 : k + 4'd1;
        EXEC: begin
          if (x_end) begin
            x <= '0;
            if (y_end) begin
              y <= '0;
              row_base <= '0;
            end else begin
              y <= y + LONE;
              row_base <= row_base + sz_i;
            end
          end else begin
            x <= x + LONE;
          end
          if (pass_end) begin
            pos   <= '0;
            wbase <= wbase + NWIDTH'(9);
            if (ch_last) begin
              m <= '0;
              ch_base <= '0;
              n <= n + LONE;
              out_nbase <= out_nbase + os2;
            end else begin
              m <= m + LONE;
              ch_base <= ch_base + s2;
            end
          end else begin
            pos <= pos + IMWIDTH'(1);
          end
        end
        WAIT: wcnt <= wcnt + WCW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      wreg_we  <= 1'b0;
      wreg_idx <= '0;
    end else begin
      wreg_we  <= net_v;
      wreg_idx <= net_v ? k : 4'd0;
    end
  end

  always_comb begin
    tap_in = '0;
    if (conv_oe) begin
      tap_in.v = 1'b1;
      tap_in.f = (m == '0);
      tap_in.l = ch_last;
      tap_in.a = out_nbase + pos;
    end
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      for (int unsigned i = 0; i < DELAY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= tap_in;
      for (int unsigned i = 1; i < DELAY; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_comb begin
    out_v     = pipe[DELAY-1].v;
    out_first = pipe[DELAY-1].v & pipe[DELAY-1].f;
    out_last  = pipe[DELAY-1].v & pipe[DELAY-1].l;
    out_addr  = pipe[DELAY-1].v ? pipe[DELAY-1].a : '0;
  end

endmodule
